// File: rtl/retry_scheduler_pkg.sv
// Shared types and helpers for the retry scheduler: FSM state encoding and the
// 16-bit LFSR step used to randomize each requester's backoff.
package retry_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    localparam int LfsrWidth = 16;

    // Maximal-length Fibonacci LFSR, taps 16,14,13,11; a non-zero seed never reaches zero.
    function automatic logic [LfsrWidth-1:0] lfsrNext(input logic [LfsrWidth-1:0] s);
        return {s[LfsrWidth-2:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/retry_scheduler_exp_backoff.sv
// Per-requester randomized exponential backoff: each set_i widens the random
// mask by one bit (up to MaxExp) and loads a fresh wait that then counts down.
module exp_backoff
    import retry_scheduler_pkg::*;
#(
    parameter int              MaxExp = 16,
    parameter logic [15:0]     Seed   = 16'h1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic set_i,
    input  logic clr_i,
    output logic is_zero_o
);

    localparam int ExpW = $clog2(MaxExp + 1);

    logic [LfsrWidth-1:0] lfsr_q, lfsr_d;
    logic [ExpW-1:0]      exp_q, exp_d;
    logic [MaxExp-1:0]    cnt_q, cnt_d;
    logic [MaxExp-1:0]    mask;

    // The LFSR free-runs so that retries from different requesters decorrelate over time.
    always_comb begin
        lfsr_d = lfsrNext(lfsr_q);
        exp_d  = exp_q;
        cnt_d  = cnt_q;
        mask   = '0;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (clr_i) begin
            exp_d = '0;
            cnt_d = '0;
        end else if (set_i) begin
            if (exp_q != ExpW'(MaxExp)) begin
                exp_d = exp_q + 1'b1;
            end
            for (int b = 0; b < MaxExp; b++) begin
                mask[b] = (b < int'(exp_d));
            end
            cnt_d = lfsr_q[MaxExp-1:0] & mask;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= Seed;
            exp_q  <= '0;
            cnt_q  <= '0;
        end else if (clear_i) begin
            lfsr_q <= Seed;
            exp_q  <= '0;
            cnt_q  <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            exp_q  <= exp_d;
            cnt_q  <= cnt_d;
        end
    end

    assign is_zero_o = (cnt_q == '0);

endmodule

// File: rtl/retry_scheduler.sv
// Round-robin arbiter for one shared atomic resource with per-requester random
// exponential backoff on failure. Define RETRY_SCHEDULER_ABORT_EN to abort after MaxRetries fails.
module retry_scheduler
    import retry_scheduler_pkg::*;
#(
    parameter int NumReq     = 4,
    parameter int MaxExp     = 16,
    parameter int SeedBase   = 'h1,
    parameter int MaxRetries = 8,
    localparam int IdxW      = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic [NumReq-1:0] req_valid_i,
    output logic [NumReq-1:0] done_o,
    output logic [NumReq-1:0] abort_o,
    output logic              issue_valid_o,
    input  logic              issue_ready_i,
    output logic [IdxW-1:0]   issue_idx_o,
    input  logic              rsp_valid_i,
    input  logic              rsp_ok_i,
    output logic              busy_o
);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [IdxW-1:0]   rr_q, rr_d;
    logic [NumReq-1:0] isZero, eligible, setVec, clrVec, idxOneHot;
    logic              pickFound;
    logic [IdxW-1:0]   pickIdx;
    logic              rspFire, okFire, failFire, abortFire;

    for (genvar k = 0; k < NumReq; k++) begin : gen_backoff
        exp_backoff #(
            .MaxExp (MaxExp),
            .Seed   (16'(SeedBase + k))
        ) u_backoff (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .clear_i   (clear_i),
            .set_i     (setVec[k]),
            .clr_i     (clrVec[k]),
            .is_zero_o (isZero[k])
        );
    end

    assign eligible = req_valid_i & isZero;

    // First eligible requester at or after rr_q, wrapping around.
    always_comb begin
        pickFound = 1'b0;
        pickIdx   = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (!pickFound && eligible[(int'(rr_q) + k) % NumReq]) begin
                pickFound = 1'b1;
                pickIdx   = IdxW'((int'(rr_q) + k) % NumReq);
            end
        end
    end

    assign rspFire   = (state_q == WAIT) && rsp_valid_i;
    assign okFire    = rspFire && rsp_ok_i;
    assign failFire  = rspFire && !rsp_ok_i;
    assign idxOneHot = NumReq'(1) << idx_q;

`ifdef RETRY_SCHEDULER_ABORT_EN
    localparam int CntW = $clog2(MaxRetries + 1);

    logic [CntW-1:0] failCnt_q [NumReq];
    logic [CntW-1:0] failCnt_d [NumReq];

    assign abortFire = failFire && (failCnt_q[idx_q] == CntW'(MaxRetries - 1));

    always_comb begin
        for (int k = 0; k < NumReq; k++) begin
            failCnt_d[k] = failCnt_q[k];
        end
        if (okFire || abortFire) begin
            failCnt_d[idx_q] = '0;
        end else if (failFire) begin
            failCnt_d[idx_q] = failCnt_q[idx_q] + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NumReq; k++) failCnt_q[k] <= '0;
        end else if (clear_i) begin
            for (int k = 0; k < NumReq; k++) failCnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NumReq; k++) failCnt_q[k] <= failCnt_d[k];
        end
    end
`else
    logic unusedMaxRetries;
    assign unusedMaxRetries = ^MaxRetries;
    assign abortFire        = 1'b0;
`endif

    assign setVec  = (failFire && !abortFire) ? idxOneHot : '0;
    assign clrVec  = (okFire || abortFire) ? idxOneHot : '0;
    assign done_o  = okFire ? idxOneHot : '0;
    assign abort_o = abortFire ? idxOneHot : '0;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (pickFound) begin
                    idx_d   = pickIdx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_ready_i) begin
                    state_d = WAIT;
                    rr_d    = (idx_q == IdxW'(NumReq - 1)) ? '0 : idx_q + 1'b1;
                end
            end
            WAIT: begin
                if (rsp_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear abandons any outstanding transaction; a late response then lands in IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rr_q    <= '0;
        end else if (clear_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
        end
    end

    assign issue_valid_o = (state_q == ISSUE);
    assign issue_idx_o   = idx_q;
    assign busy_o        = (state_q != IDLE);

    assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
                     (state_q != IDLE) |-> req_valid_i[idx_q]);

endmodule

// File: tb/tb_retry_scheduler.sv
// Scenario bench for retry_scheduler (NumReq=4, MaxExp=1, MaxRetries=2);
// inputs change on the falling edge and outputs are sampled 1 ns later.
module tb_retry_scheduler;

    localparam int NumReq     = 4;
    localparam int MaxRetries = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] reqValid = '0;
    logic [3:0] done;
    logic [3:0] abort;
    logic       issueValid;
    logic       issueReady = 1'b0;
    logic [1:0] issueIdx;
    logic       rspValid = 1'b0;
    logic       rspOk = 1'b0;
    logic       busy;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    retry_scheduler #(
        .NumReq     (NumReq),
        .MaxExp     (1),
        .SeedBase   (1),
        .MaxRetries (MaxRetries)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clear_i       (clear),
        .req_valid_i   (reqValid),
        .done_o        (done),
        .abort_o       (abort),
        .issue_valid_o (issueValid),
        .issue_ready_i (issueReady),
        .issue_idx_o   (issueIdx),
        .rsp_valid_i   (rspValid),
        .rsp_ok_i      (rspOk),
        .busy_o        (busy)
    );

    // Bring every input and the DUT back to a quiet, freshly-cleared state.
    task automatic doClear;
        @(negedge clk);
        clear = 1'b1; reqValid = '0; rspValid = 1'b0; rspOk = 1'b0; issueReady = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        #1;
    endtask

    task automatic waitIssue(input int budget, output bit seen, output int cycles);
        cycles = 0;
        seen = issueValid;
        while (!seen && cycles < budget) begin
            @(negedge clk); #1;
            cycles++;
            seen = issueValid;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        compared++; if (issueValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_issue_valid got %b want 0", issueValid); end
        compared++; if (issueIdx !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_issue_idx got %0d want 0", issueIdx); end
        compared++; if (done !== 4'b0) begin mismatched++; $display("[TB] FAIL reset_done got %b want 0000", done); end
        compared++; if (abort !== 4'b0) begin mismatched++; $display("[TB] FAIL reset_abort got %b want 0000", abort); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        doClear();
        @(negedge clk);
        reqValid = 4'b0100; issueReady = 1'b1;
        @(negedge clk); #1;
        compared++; if (issueValid !== 1'b1) begin mismatched++; $display("[TB] FAIL single_issue_valid got %b want 1", issueValid); end
        compared++; if (issueIdx !== 2'd2) begin mismatched++; $display("[TB] FAIL single_issue_idx got %0d want 2", issueIdx); end
        @(negedge clk);
        rspValid = 1'b1; rspOk = 1'b1;
        #1;
        compared++; if (done !== 4'b0100) begin mismatched++; $display("[TB] FAIL single_done got %b want 0100", done); end
        @(negedge clk);
        rspValid = 1'b0; reqValid = '0;
        #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL single_busy_after got %b want 0", busy); end
        compared++; if (done !== 4'b0) begin mismatched++; $display("[TB] FAIL single_done_after got %b want 0000", done); end
    endtask

    task automatic test_fairness;
        int order [5] = '{0, 1, 2, 3, 0};
        bit seen;
        int cycles;
        doClear();
        @(negedge clk);
        reqValid = 4'b1111; issueReady = 1'b1;
        #1;
        for (int n = 0; n < 5; n++) begin
            waitIssue(8, seen, cycles);
            compared++;
            if (!seen) begin mismatched++; $display("[TB] FAIL fair_timeout txn %0d got no issue want issue", n); return; end
            compared++;
            if (issueIdx !== 2'(order[n])) begin mismatched++; $display("[TB] FAIL fair_order txn %0d got %0d want %0d", n, issueIdx, order[n]); end
            @(negedge clk);
            rspValid = 1'b1; rspOk = 1'b1;
            #1;
            compared++;
            if (done !== (4'b1 << order[n])) begin mismatched++; $display("[TB] FAIL fair_done txn %0d got %b want %b", n, done, 4'b1 << order[n]); end
            @(negedge clk);
            rspValid = 1'b0;
            reqValid[order[n]] = 1'b0;
            if (n == 3) reqValid[0] = 1'b1;
            #1;
        end
        reqValid = '0;
    endtask

    task automatic test_backoff;
`ifdef RETRY_SCHEDULER_ABORT_EN
        int numFails = MaxRetries - 1;
`else
        int numFails = 3;
`endif
        int doneCount = 0;
        int abortCount = 0;
        bit seen;
        int cycles;
        doClear();
        @(negedge clk);
        reqValid = 4'b0001; issueReady = 1'b1;
        #1;
        for (int n = 0; n <= numFails; n++) begin
            waitIssue(6, seen, cycles);
            compared++;
            if (!seen) begin mismatched++; $display("[TB] FAIL backoff_timeout try %0d got no issue want issue", n); return; end
            if (n > 0) begin
                compared++;
                if (cycles + 1 > 4) begin mismatched++; $display("[TB] FAIL backoff_gap try %0d got %0d cycles want <=4", n, cycles + 1); end
            end
            @(negedge clk);
            rspValid = 1'b1; rspOk = (n == numFails);
            #1;
            if (done[0]) doneCount++;
            if (abort !== 4'b0) abortCount++;
            @(negedge clk);
            rspValid = 1'b0;
            if (n == numFails) reqValid = '0;
            #1;
        end
        compared++; if (doneCount != 1) begin mismatched++; $display("[TB] FAIL backoff_done_count got %0d want 1", doneCount); end
        compared++; if (abortCount != 0) begin mismatched++; $display("[TB] FAIL backoff_abort_count got %0d want 0", abortCount); end
    endtask

    task automatic test_ready_stall;
        int handshakes = 0;
        bit seen;
        int cycles;
        doClear();
        @(negedge clk);
        reqValid = 4'b1000; issueReady = 1'b0;
        #1;
        waitIssue(6, seen, cycles);
        compared++;
        if (!seen) begin mismatched++; $display("[TB] FAIL stall_timeout got no issue want issue"); return; end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (issueValid && issueReady) handshakes++;
            compared++;
            if (issueValid !== 1'b1 || issueIdx !== 2'd3) begin mismatched++; $display("[TB] FAIL stall_hold cycle %0d got valid=%b idx=%0d want valid=1 idx=3", c, issueValid, issueIdx); end
        end
        @(negedge clk);
        issueReady = 1'b1;
        #1;
        if (issueValid && issueReady) handshakes++;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            if (issueValid && issueReady) handshakes++;
        end
        @(negedge clk);
        rspValid = 1'b1; rspOk = 1'b1;
        #1;
        compared++; if (done !== 4'b1000) begin mismatched++; $display("[TB] FAIL stall_done got %b want 1000", done); end
        @(negedge clk);
        rspValid = 1'b0; reqValid = '0; issueReady = 1'b0;
        #1;
        compared++; if (handshakes != 1) begin mismatched++; $display("[TB] FAIL stall_handshakes got %0d want 1", handshakes); end
    endtask

    task automatic test_abort;
        bit seen;
        int cycles;
        doClear();
        @(negedge clk);
        reqValid = 4'b0010; issueReady = 1'b1;
        #1;
`ifdef RETRY_SCHEDULER_ABORT_EN
        for (int n = 1; n <= MaxRetries; n++) begin
            waitIssue(6, seen, cycles);
            compared++;
            if (!seen) begin mismatched++; $display("[TB] FAIL abort_timeout fail %0d got no issue want issue", n); return; end
            @(negedge clk);
            rspValid = 1'b1; rspOk = 1'b0;
            #1;
            compared++;
            if (abort !== ((n == MaxRetries) ? 4'b0010 : 4'b0000)) begin mismatched++; $display("[TB] FAIL abort_pulse fail %0d got %b want %b", n, abort, (n == MaxRetries) ? 4'b0010 : 4'b0000); end
            compared++;
            if (done !== 4'b0) begin mismatched++; $display("[TB] FAIL abort_done fail %0d got %b want 0000", n, done); end
            @(negedge clk);
            rspValid = 1'b0;
            if (n == MaxRetries) reqValid = '0;
            #1;
        end
        @(negedge clk); #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_idle got busy=%b want 0", busy); end
`else
        for (int n = 1; n <= 5; n++) begin
            waitIssue(6, seen, cycles);
            compared++;
            if (!seen) begin mismatched++; $display("[TB] FAIL noabort_timeout try %0d got no issue want issue", n); return; end
            @(negedge clk);
            rspValid = 1'b1; rspOk = (n == 5);
            #1;
            compared++;
            if (abort !== 4'b0) begin mismatched++; $display("[TB] FAIL noabort_abort try %0d got %b want 0000", n, abort); end
            compared++;
            if (done !== ((n == 5) ? 4'b0010 : 4'b0000)) begin mismatched++; $display("[TB] FAIL noabort_done try %0d got %b want %b", n, done, (n == 5) ? 4'b0010 : 4'b0000); end
            @(negedge clk);
            rspValid = 1'b0;
            if (n == 5) reqValid = '0;
            #1;
        end
`endif
    endtask

    task automatic test_clear_in_wait;
        doClear();
        @(negedge clk);
        reqValid = 4'b0001; issueReady = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        compared++; if (busy !== 1'b1 || issueValid !== 1'b0) begin mismatched++; $display("[TB] FAIL clear_setup got busy=%b valid=%b want busy=1 valid=0", busy, issueValid); end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; reqValid = '0; rspValid = 1'b1; rspOk = 1'b1;
        #1;
        compared++; if (done !== 4'b0) begin mismatched++; $display("[TB] FAIL clear_late_done got %b want 0000", done); end
        compared++; if (busy !== 1'b0 || issueValid !== 1'b0 || issueIdx !== 2'd0 || abort !== 4'b0) begin
            mismatched++; $display("[TB] FAIL clear_outputs got busy=%b valid=%b idx=%0d abort=%b want 0 0 0 0000", busy, issueValid, issueIdx, abort);
        end
        @(negedge clk);
        rspValid = 1'b0;
        #1;
        compared++; if (busy !== 1'b0 || done !== 4'b0) begin mismatched++; $display("[TB] FAIL clear_after got busy=%b done=%b want 0 0000", busy, done); end
    endtask

    task automatic test_async_reset;
        bit seen;
        int cycles;
        doClear();
        @(negedge clk);
        reqValid = 4'b0100; issueReady = 1'b0;
        #1;
        waitIssue(6, seen, cycles);
        compared++;
        if (!seen) begin mismatched++; $display("[TB] FAIL areset_timeout got no issue want issue"); return; end
        #1;
        rst_n = 1'b0;
        #1;
        compared++; if (issueValid !== 1'b0 || busy !== 1'b0 || issueIdx !== 2'd0) begin
            mismatched++; $display("[TB] FAIL areset_immediate got valid=%b busy=%b idx=%0d want 0 0 0", issueValid, busy, issueIdx);
        end
        @(negedge clk);
        rst_n = 1'b1; reqValid = '0;
        #1;
    endtask

    // Reference: pick = first pending requester at/after the rr pointer; a requester that
    // just failed may sit out one cycle (MaxExp=1 caps its wait at 1), so it may be skipped.
    task automatic test_random;
        bit   pend [NumReq];
        int   failCnt [NumReq];
        int   rrModel = 0;
        int   lastFail = -1;
        int   expA, expB, p, d;
        bit   ok, seen, hs;
        int   cycles;
        logic [3:0] expDone, expAbort;
        doClear();
        for (int k = 0; k < NumReq; k++) begin pend[k] = 1'b0; failCnt[k] = 0; end
        @(negedge clk);
        for (int t = 0; t < 60; t++) begin
            for (int k = 0; k < NumReq; k++) if (!pend[k] && $urandom_range(0, 2) == 0) pend[k] = 1'b1;
            if (!(pend[0] || pend[1] || pend[2] || pend[3])) pend[$urandom_range(0, 3)] = 1'b1;
            for (int k = 0; k < NumReq; k++) reqValid[k] = pend[k];
            issueReady = ($urandom_range(0, 2) != 0);
            #1;
            waitIssue(6, seen, cycles);
            compared++;
            if (!seen) begin mismatched++; $display("[TB] FAIL rand_timeout txn %0d got no issue want issue", t); return; end
            expA = -1; expB = -1;
            for (int k = 0; k < NumReq; k++) begin
                p = (rrModel + k) % NumReq;
                if (pend[p] && expB < 0) expB = p;
                if (pend[p] && p != lastFail && expA < 0) expA = p;
            end
            p = int'(issueIdx);
            compared++;
            if (p != expB && p != expA) begin mismatched++; $display("[TB] FAIL rand_pick txn %0d got %0d want %0d or %0d", t, p, expB, expA); end
            hs = issueReady;
            for (int c = 0; c < 12 && !hs; c++) begin
                @(negedge clk);
                issueReady = (c >= 6) || ($urandom_range(0, 2) != 0);
                #1;
                compared++;
                if (issueValid !== 1'b1 || int'(issueIdx) != p) begin mismatched++; $display("[TB] FAIL rand_stall txn %0d got valid=%b idx=%0d want 1 %0d", t, issueValid, issueIdx, p); end
                hs = issueReady;
            end
            rrModel = (p + 1) % NumReq;
            lastFail = -1;
            d = $urandom_range(0, 2);
            for (int c = 0; c < d; c++) begin
                @(negedge clk);
                issueReady = 1'b0;
                #1;
            end
            @(negedge clk);
            ok = ($urandom_range(0, 9) < 6);
            issueReady = 1'b0; rspValid = 1'b1; rspOk = ok;
            #1;
            expDone = '0; expAbort = '0;
            if (ok) begin
                expDone[p] = 1'b1;
                pend[p] = 1'b0;
                failCnt[p] = 0;
            end else begin
                failCnt[p]++;
`ifdef RETRY_SCHEDULER_ABORT_EN
                if (failCnt[p] == MaxRetries) begin
                    expAbort[p] = 1'b1;
                    pend[p] = 1'b0;
                    failCnt[p] = 0;
                end else begin
                    lastFail = p;
                end
`else
                lastFail = p;
`endif
            end
            compared++;
            if (done !== expDone || abort !== expAbort) begin mismatched++; $display("[TB] FAIL rand_rsp txn %0d got done=%b abort=%b want %b %b", t, done, abort, expDone, expAbort); end
            @(negedge clk);
            rspValid = 1'b0;
        end
        reqValid = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            if (issueValid) begin
                issueReady = 1'b1;
                reqValid = 4'b1 << issueIdx;
            end
        end
        doClear();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backoff();
        test_ready_stall();
        test_abort();
        test_clear_in_wait();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout got no finish want finish");
        $fatal(1, "[TB] global timeout");
    end

endmodule
